// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port. Outstanding requests are
// throttled at MAX_OUT, and a watchdog forces an error when the slave stays silent.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int MAX_OUT = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [NM-1:0]    m_cyc,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*32-1:0] m_addr,
  input  logic [NM*32-1:0] m_data,
  input  logic [NM*4-1:0]  m_sel,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_stall,
  output logic [NM-1:0]    m_err,
  output logic             o_cyc,
  output logic             o_stb,
  output logic             o_we,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_data,
  output logic [3:0]       o_sel,
  input  logic             o_ack,
  input  logic             o_stall,
  input  logic             o_err,
  output logic [NM-1:0]    grant,
  output logic             timeout_err
);
  localparam int IW = $clog2(NM);
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_OWNED = 1'b1;
  localparam logic [3:0]  MAX_CNT = 4'(MAX_OUT);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [0:0]    state;
  logic [IW-1:0] owner, last, pick, cand;
  logic          found;
  logic [3:0]    count;
  logic [15:0]   wdog;
  logic          owned, throttled, accept, ack_dec, wd_clear, wd_fire;
  logic [31:0]   addr_arr [NM];
  logic [31:0]   data_arr [NM];
  logic [3:0]    sel_arr  [NM];

  for (genvar i = 0; i < NM; i++) begin : g_master
    assign addr_arr[i] = m_addr[i*32 +: 32];
    assign data_arr[i] = m_data[i*32 +: 32];
    assign sel_arr[i]  = m_sel[i*4 +: 4];
    assign m_stall[i]  = !grant[i] || o_stall || throttled;
    assign m_ack[i]    = grant[i] && o_ack;
    assign m_err[i]    = grant[i] && (o_err || timeout_err);
  end

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= NM; k++) begin
      cand = IW'((int'(last) + k) % NM);
      if (!found && m_cyc[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owned     = (state == S_OWNED);
  assign throttled = owned && (count == MAX_CNT);
  assign o_cyc     = owned && m_cyc[owner];
  assign o_stb     = o_cyc && m_stb[owner] && !throttled;
  assign o_we      = owned && m_we[owner];
  assign o_addr    = owned ? addr_arr[owner] : '0;
  assign o_data    = owned ? data_arr[owner] : '0;
  assign o_sel     = owned ? sel_arr[owner]  : '0;

  assign accept   = o_stb && !o_stall;
  assign ack_dec  = o_ack && (count != 4'd0);
  assign wd_clear = !owned || o_ack || o_err || (count == 4'd0);
  assign wd_fire  = !wd_clear && (wdog == WD_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      grant       <= '0;
      owner       <= '0;
      last        <= IW'(NM - 1);
      count       <= 4'd0;
      wdog        <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (state == S_IDLE) begin
        count <= 4'd0;
        wdog  <= 16'd0;
        if (found) begin
          state <= S_OWNED;
          owner <= pick;
          last  <= pick;
          grant <= NM'(1) << pick;
        end
      end else if (!m_cyc[owner]) begin
        // Release drops all bookkeeping; late acks then find no granted master.
        state <= S_IDLE;
        grant <= '0;
        count <= 4'd0;
        wdog  <= 16'd0;
      end else begin
        if (o_err || wd_fire)
          count <= 4'd0;
        else if (accept && !ack_dec)
          count <= count + 4'd1;
        else if (!accept && ack_dec)
          count <= count - 4'd1;

        if (wd_clear) begin
          wdog <= 16'd0;
        end else if (wd_fire) begin
          wdog        <= 16'd0;
          timeout_err <= 1'b1;
        end else begin
          wdog <= wdog + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus randomized traffic compared cycle by
// cycle against an integer-level model of the arbitration and flow-control rules.
module tb_wb_rr_arbiter;
  localparam int NM      = 4;
  localparam int MAX_OUT = 7;
  localparam int TIMEOUT = 10;

  logic          CLK, nRST;
  logic [3:0]    m_cyc, m_stb, m_we;
  logic [31:0]   addr_a [4];
  logic [31:0]   data_a [4];
  logic [3:0]    sel_a  [4];
  logic [127:0]  m_addr, m_data;
  logic [15:0]   m_sel;
  logic [3:0]    m_ack, m_stall, m_err, grant;
  logic          o_cyc, o_stb, o_we, o_ack, o_stall, o_err, timeout_err;
  logic [31:0]   o_addr, o_data;
  logic [3:0]    o_sel;

  int nchk = 0;
  int npass = 0;

  always_comb m_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  always_comb m_data = {data_a[3], data_a[2], data_a[1], data_a[0]};
  always_comb m_sel  = {sel_a[3], sel_a[2], sel_a[1], sel_a[0]};

  wb_rr_arbiter #(.NM(NM), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_addr(m_addr), .m_data(m_data), .m_sel(m_sel),
    .m_ack(m_ack), .m_stall(m_stall), .m_err(m_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .o_ack(o_ack), .o_stall(o_stall), .o_err(o_err),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: owner index (-1 when idle), last winner, outstanding count,
  // silent-cycle count and the timeout pulse.
  typedef struct packed {
    int own;
    int last;
    int cnt;
    int wd;
    bit tmo;
  } mdl_t;

  mdl_t mdl;

  function automatic logic [87:0] exp_vec(input mdl_t s);
    logic [3:0]  g   = 4'd0;
    logic [3:0]  ack = 4'd0;
    logic [3:0]  stl = 4'hF;
    logic [3:0]  err = 4'd0;
    logic        ocyc = 1'b0, ostb = 1'b0, we = 1'b0;
    logic [31:0] a = 32'd0, d = 32'd0;
    logic [3:0]  sl = 4'd0;
    logic [1:0]  oi;
    bit          thr;
    if (s.own >= 0) begin
      oi      = s.own[1:0];
      thr     = (s.cnt == MAX_OUT);
      g[oi]   = 1'b1;
      ocyc    = m_cyc[oi];
      ostb    = ocyc && m_stb[oi] && !thr;
      we      = m_we[oi];
      a       = addr_a[oi];
      d       = data_a[oi];
      sl      = sel_a[oi];
      stl[oi] = o_stall || thr;
      ack[oi] = o_ack;
      err[oi] = o_err || s.tmo;
    end
    return {g, ocyc, ostb, we, a, d, sl, ack, stl, err, s.tmo};
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s);
    mdl_t       n = s;
    logic [1:0] idx;
    logic [1:0] oi;
    bit         found = 0;
    bit         acc, dec, fire;
    int         c;
    n.tmo = 0;
    if (s.own < 0) begin
      n.cnt = 0;
      n.wd  = 0;
      for (int k = 1; k <= NM; k++) begin
        c   = (s.last + k) % NM;
        idx = c[1:0];
        if (!found && m_cyc[idx]) begin
          found  = 1;
          n.own  = c;
          n.last = c;
        end
      end
    end else begin
      oi = s.own[1:0];
      if (!m_cyc[oi]) begin
        n.own = -1;
        n.cnt = 0;
        n.wd  = 0;
      end else begin
        acc  = m_stb[oi] && (s.cnt != MAX_OUT) && !o_stall;
        dec  = o_ack && (s.cnt > 0);
        fire = 0;
        if (o_ack || o_err || s.cnt == 0) n.wd = 0;
        else if (s.wd + 1 == TIMEOUT) begin
          fire  = 1;
          n.wd  = 0;
          n.tmo = 1;
        end else n.wd = s.wd + 1;
        if (o_err || fire) n.cnt = 0;
        else n.cnt = s.cnt + int'(acc) - int'(dec);
      end
    end
    return n;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) mdl <= '{own: -1, last: NM - 1, cnt: 0, wd: 0, tmo: 1'b0};
    else       mdl <= mdl_next(mdl);
  end

  task automatic clear_inputs();
    m_cyc = 4'd0; m_stb = 4'd0; m_we = 4'd0;
    o_ack = 1'b0; o_stall = 1'b0; o_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 32'h1000_0000 * (i + 1) + 32'h44;
      data_a[i] = 32'hD000_0000 + i;
      sel_a[i]  = 4'hF;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    m_cyc = 4'hF; m_stb = 4'hF; o_ack = 1'b1; o_err = 1'b1;
    #3;
    nchk++; if (grant !== 4'd0 || o_cyc !== 1'b0 || o_stb !== 1'b0)
      $display("FAIL reset_bus: grant=%b o_cyc=%b o_stb=%b want 0000/0/0", grant, o_cyc, o_stb);
    else npass++;
    nchk++; if (m_stall !== 4'hF || m_ack !== 4'd0 || m_err !== 4'd0 || timeout_err !== 1'b0)
      $display("FAIL reset_status: stall=%b ack=%b err=%b tmo=%b want 1111/0000/0000/0", m_stall, m_ack, m_err, timeout_err);
    else npass++;
    @(posedge CLK); #1;
    nchk++; if (grant !== 4'd0 || o_cyc !== 1'b0)
      $display("FAIL reset_held: grant=%b o_cyc=%b want 0000/0", grant, o_cyc);
    else npass++;
    @(negedge CLK);
    clear_inputs();
    nRST = 1'b1;
  endtask

  task automatic test_rr_order();
    logic [3:0] g;
    @(negedge CLK); m_cyc = 4'hF; #1;
    nchk++; if (grant !== 4'd0 || o_cyc !== 1'b0)
      $display("FAIL rr_latency: grant=%b o_cyc=%b want 0000/0", grant, o_cyc);
    else npass++;
    for (int i = 0; i < 4; i++) begin
      g = 4'b1 << i;
      @(negedge CLK); #1;
      nchk++; if (grant !== g || o_cyc !== 1'b1 || m_stall !== ~g)
        $display("FAIL rr_grant%0d: grant=%b o_cyc=%b stall=%b want %b/1/%b", i, grant, o_cyc, m_stall, g, ~g);
      else npass++;
      @(negedge CLK); #1;
      nchk++; if (grant !== g)
        $display("FAIL rr_hold%0d: grant=%b want %b", i, grant, g);
      else npass++;
      @(negedge CLK); m_cyc = m_cyc & ~g; #1;
      nchk++; if (o_cyc !== 1'b0 || grant !== g)
        $display("FAIL rr_release%0d: o_cyc=%b grant=%b want 0/%b", i, o_cyc, grant, g);
      else npass++;
      @(negedge CLK); #1;
      nchk++; if (grant !== 4'd0 || o_cyc !== 1'b0)
        $display("FAIL rr_idle%0d: grant=%b o_cyc=%b want 0000/0", i, grant, o_cyc);
      else npass++;
    end
  endtask

  task automatic test_throttle();
    bit exp_stb;
    @(negedge CLK); m_cyc = 4'b0010; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b0010)
      $display("FAIL thr_grant: grant=%b want 0010", grant);
    else npass++;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK); m_stb[1] = 1'b1; #1;
      exp_stb = (k < MAX_OUT);
      nchk++; if (o_stb !== exp_stb || m_stall[1] !== !exp_stb)
        $display("FAIL thr_strobe%0d: o_stb=%b stall=%b want %b/%b", k, o_stb, m_stall[1], exp_stb, !exp_stb);
      else npass++;
    end
    @(negedge CLK); o_ack = 1'b1; #1;
    nchk++; if (o_stb !== 1'b0 || m_ack[1] !== 1'b1)
      $display("FAIL thr_ack_cycle: o_stb=%b ack=%b want 0/1", o_stb, m_ack[1]);
    else npass++;
    @(negedge CLK); o_ack = 1'b0; #1;
    nchk++; if (o_stb !== 1'b1 || m_stall[1] !== 1'b0)
      $display("FAIL thr_reopen: o_stb=%b stall=%b want 1/0", o_stb, m_stall[1]);
    else npass++;
    @(negedge CLK); #1;
    nchk++; if (o_stb !== 1'b0 || m_stall[1] !== 1'b1)
      $display("FAIL thr_reclose: o_stb=%b stall=%b want 0/1", o_stb, m_stall[1]);
    else npass++;
    @(negedge CLK); m_stb = 4'd0; m_cyc = 4'd0; #1;
    @(negedge CLK); #1;
  endtask

  task automatic test_release();
    @(negedge CLK); m_cyc = 4'b0100; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b0100)
      $display("FAIL rel_grant: grant=%b want 0100", grant);
    else npass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); m_stb[2] = 1'b1; #1;
    end
    @(negedge CLK); m_stb = 4'd0; m_cyc = 4'd0; #1;
    nchk++; if (o_cyc !== 1'b0 || grant !== 4'b0100)
      $display("FAIL rel_same_cycle: o_cyc=%b grant=%b want 0/0100", o_cyc, grant);
    else npass++;
    @(negedge CLK); o_ack = 1'b1; #1;
    nchk++; if (grant !== 4'd0 || m_ack !== 4'd0)
      $display("FAIL rel_late_ack: grant=%b ack=%b want 0000/0000", grant, m_ack);
    else npass++;
    @(negedge CLK); #1;
    nchk++; if (m_ack !== 4'd0 || o_cyc !== 1'b0)
      $display("FAIL rel_late_ack2: ack=%b o_cyc=%b want 0000/0", m_ack, o_cyc);
    else npass++;
    o_ack = 1'b0;
  endtask

  task automatic test_timeout();
    bit e;
    @(negedge CLK); m_cyc = 4'b1000; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b1000)
      $display("FAIL tmo_grant: grant=%b want 1000", grant);
    else npass++;
    @(negedge CLK); m_stb[3] = 1'b1; #1;
    nchk++; if (o_stb !== 1'b1)
      $display("FAIL tmo_accept: o_stb=%b want 1", o_stb);
    else npass++;
    // The accepting edge closes sample 0; the pulse is set by the tenth edge after it.
    for (int j = 1; j <= 12; j++) begin
      @(negedge CLK); m_stb = 4'd0; #1;
      e = (j == 11);
      nchk++; if (timeout_err !== e || m_err[3] !== e || grant !== 4'b1000)
        $display("FAIL tmo_cycle%0d: tmo=%b err=%b grant=%b want %b/%b/1000", j, timeout_err, m_err[3], grant, e, e);
      else npass++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK); m_stb[3] = 1'b1; #1;
      e = (k < MAX_OUT);
      nchk++; if (o_stb !== e)
        $display("FAIL tmo_count_cleared%0d: o_stb=%b want %b", k, o_stb, e);
      else npass++;
    end
    @(negedge CLK); m_stb = 4'd0; m_cyc = 4'd0; #1;
    @(negedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); m_cyc = 4'b0010; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b0010)
      $display("FAIL rmid_grant: grant=%b want 0010", grant);
    else npass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); m_stb[1] = 1'b1; #1;
    end
    @(negedge CLK); m_stb = 4'd0; #2;
    nRST = 1'b0; #1;
    nchk++; if (grant !== 4'd0 || o_cyc !== 1'b0 || m_stall !== 4'hF)
      $display("FAIL rmid_async: grant=%b o_cyc=%b stall=%b want 0000/0/1111", grant, o_cyc, m_stall);
    else npass++;
    @(negedge CLK); m_cyc = 4'b1001; #1;
    nchk++; if (grant !== 4'd0)
      $display("FAIL rmid_held: grant=%b want 0000", grant);
    else npass++;
    @(negedge CLK); nRST = 1'b1; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b0001)
      $display("FAIL rmid_favour0: grant=%b want 0001", grant);
    else npass++;
    @(negedge CLK); m_cyc = 4'd0; #1;
    @(negedge CLK); #1;
  endtask

  task automatic test_ack_and_err();
    bit e;
    @(negedge CLK); m_cyc = 4'b0010; #1;
    @(negedge CLK); #1;
    nchk++; if (grant !== 4'b0010)
      $display("FAIL ae_grant: grant=%b want 0010", grant);
    else npass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); m_stb[1] = 1'b1; #1;
    end
    @(negedge CLK); o_ack = 1'b1; #1;
    nchk++; if (o_stb !== 1'b1)
      $display("FAIL ae_simul: o_stb=%b want 1", o_stb);
    else npass++;
    // Count held at 4: exactly three more strobes fit before throttling.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); o_ack = 1'b0; #1;
      e = (k < 3);
      nchk++; if (o_stb !== e)
        $display("FAIL ae_after_simul%0d: o_stb=%b want %b", k, o_stb, e);
      else npass++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); m_stb = 4'd0; o_ack = 1'b1; #1;
    end
    @(negedge CLK); o_ack = 1'b0; o_err = 1'b1; #1;
    nchk++; if (m_err !== 4'b0010)
      $display("FAIL ae_err_route: err=%b want 0010", m_err);
    else npass++;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK); o_err = 1'b0; m_stb[1] = 1'b1; #1;
      e = (k < MAX_OUT);
      nchk++; if (o_stb !== e)
        $display("FAIL ae_err_clear%0d: o_stb=%b want %b", k, o_stb, e);
      else npass++;
    end
    @(negedge CLK); m_stb = 4'd0; m_cyc = 4'd0; #1;
    @(negedge CLK); #1;
  endtask

  task automatic test_random(input int cycles, input int ack_div);
    logic [87:0] act, expv;
    for (int k = 0; k < cycles; k++) begin
      @(negedge CLK);
      m_cyc   = m_cyc ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      m_stb   = 4'($urandom);
      m_we    = 4'($urandom);
      o_stall = ($urandom_range(3) == 0);
      o_ack   = ($urandom_range(ack_div) == 0);
      o_err   = ($urandom_range(31) == 0);
      for (int i = 0; i < 4; i++) begin
        addr_a[i] = $urandom;
        data_a[i] = $urandom;
        sel_a[i]  = 4'($urandom);
      end
      #1;
      act  = {grant, o_cyc, o_stb, o_we, o_addr, o_data, o_sel, m_ack, m_stall, m_err, timeout_err};
      expv = exp_vec(mdl);
      nchk++; if (act !== expv)
        $display("FAIL rand_cycle%0d: got %h want %h", k, act, expv);
      else npass++;
    end
    @(negedge CLK); clear_inputs(); #1;
    @(negedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_throttle();
    test_release();
    test_timeout();
    test_reset_mid();
    test_ack_and_err();
    test_random(400, 2);
    test_random(300, 15);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run exceeded 500000 time units");
    $fatal(1);
  end
endmodule
